mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the max number of cycles mem_req_o stays high waiting for ack (legal range 1..255).
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-low (asserted when 0).
REQ-004 MemRead_i  input  1  load in MEM stage (from EX/MEM register).
REQ-005 MemWrite_i  input  1  store in MEM stage (from EX/MEM register).
REQ-006 ALU_i  input  32  byte address (EX/MEM ALU result).
REQ-007 rt_i  input  32  store data (EX/MEM rt).
REQ-008 mem_req_o  output  1  request to data memory; held until ack or timeout.
REQ-009 mem_we_o  output  1  1 = write, 0 = read; valid while mem_req_o=1.
REQ-010 mem_addr_o  output  32  latched address; valid while mem_req_o=1.
REQ-011 mem_wdata_o  output  32  latched store data; valid while mem_req_o=1.
REQ-012 mem_ack_i  input  1  memory completion, one-cycle pulse, sampled only while mem_req_o=1.
REQ-013 mem_rdata_i  input  32  load data, valid in mem_ack_i cycle.
REQ-014 stall_o  output  1  freezes PC, IF/ID, ID/EX and EX/MEM registers.
REQ-015 rdata_o  output  32  registered load result for MEM/WB.
REQ-016 rdata_valid_o  output  1  one-cycle pulse: rdata_o updated by a completed load.
REQ-017 err_o  output  1  sticky error: misaligned access or timeout.

Function
REQ-018 FSM states SHALL be IDLE, REQ, DONE; encoding free.
REQ-019 IDLE: access = MemRead_i | MemWrite_i; if access and ALU_i[1:0]==0, stall_o SHALL be 1 combinationally that cycle, address/data/we latched, next state REQ.
REQ-020 IDLE with MemRead_i=MemWrite_i=1 SHALL be treated as a write.
REQ-021 IDLE with access and ALU_i[1:0]!=0: no request, stall_o=0, err_o set to 1 next edge, state stays IDLE.
REQ-022 REQ: mem_req_o=1 and stall_o=1 every cycle; mem_addr_o/mem_wdata_o/mem_we_o SHALL remain stable.
REQ-023 Wait counter SHALL clear on entry to REQ and increment each REQ cycle without mem_ack_i.
REQ-024 REQ with mem_ack_i=1: next state DONE; if read, rdata_o <= mem_rdata_i.
REQ-025 REQ with no ack and counter==TIMEOUT-1: next state DONE, err_o <= 1, rdata_o unchanged; mem_req_o high exactly TIMEOUT cycles.
REQ-026 Ack in the timeout cycle SHALL win: normal completion, err_o unchanged.
REQ-027 DONE: mem_req_o=0, stall_o=0 (pipeline advances one cycle), rdata_valid_o=1 only if completed access was a read with ack; inputs ignored; next state IDLE.
REQ-028 Minimum latency with immediate ack: access seen in IDLE cycle N, mem_req_o high N+1, DONE N+2, stall_o high cycles N..N+1 (2 cycles).
REQ-029 rdata_o SHALL hold its value until the next acknowledged read; writes never change it.
REQ-030 err_o SHALL stay 1 until reset; it never stalls or blocks later accesses.
REQ-031 mem_ack_i outside REQ SHALL be ignored.

Reset
REQ-032 With rst=0 at a posedge: state IDLE, counter 0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0, rdata_valid_o=0, err_o=0.
REQ-033 stall_o SHALL be 0 while rst=0.
REQ-034 Reset during REQ SHALL drop mem_req_o at that edge with no rdata_o update; a late ack after reset is ignored.

Verification
REQ-035 Load, ack after 3 cycles: MemRead_i=1, ALU_i=0x100, mem_rdata_i=0xDEADBEEF -> mem_req_o high 3 cycles, addr 0x100, we 0; stall_o high 4 cycles; DONE: rdata_valid_o=1, rdata_o=0xDEADBEEF.
REQ-036 Store, immediate ack: MemWrite_i=1, ALU_i=0x20, rt_i=0x12345678 -> mem_we_o=1, mem_wdata_o=0x12345678 for 1 cycle; stall_o 2 cycles; rdata_valid_o stays 0; rdata_o unchanged.
REQ-037 Timeout (TIMEOUT=4), no ack: mem_req_o high exactly 4 cycles, then DONE, err_o=1, rdata_valid_o=0; next access still served.
REQ-038 Misaligned ALU_i=0x102 with MemRead_i=1 -> mem_req_o never asserted, stall_o=0, err_o=1 next cycle.
REQ-039 Ack in 4th cycle with TIMEOUT=4 -> normal completion, err_o=0; back-to-back loads -> second request starts 1 cycle after DONE.
REQ-040 rst=0 while in REQ -> mem_req_o=0 and all outputs at reset values next cycle; ack one cycle later ignored.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the MEM stage: issues one request per load/store,
// stalls the pipeline until ack or timeout, and captures load data for MEM/WB.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [31:0] ALU_i,
   input  logic [31:0] rt_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        rdata_valid_o,
   output logic        err_o
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [7:0]  cnt;
   logic        we_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [31:0] rdata_r;
   logic        rd_ok_r;
   logic        err_r;

   logic        access;
   logic        aligned;
   logic        launch;
   logic        ack_hit;
   logic        timed_out;
   logic        misaligned;

   assign access     = MemRead_i | MemWrite_i;
   assign aligned    = (ALU_i[1:0] == 2'b00);
   assign misaligned = (state == IDLE) && access && !aligned;

   always_comb begin
      state_nxt     = state;
      launch        = 1'b0;
      ack_hit       = 1'b0;
      timed_out     = 1'b0;
      mem_req_o     = 1'b0;
      stall_o       = 1'b0;
      rdata_valid_o = 1'b0;
      case (state)
         IDLE: begin
            if (access && aligned) begin
               launch    = 1'b1;
               stall_o   = rst;
               state_nxt = REQ;
            end
         end
         REQ: begin
            mem_req_o = 1'b1;
            stall_o   = rst;
            // Ack in the final allowed cycle still counts as a normal completion
            if (mem_ack_i) begin
               ack_hit   = 1'b1;
               state_nxt = DONE;
            end else if (cnt == TIMEOUT_M1) begin
               timed_out = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            rdata_valid_o = rd_ok_r;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= 8'd0;
         we_r    <= 1'b0;
         addr_r  <= 32'd0;
         wdata_r <= 32'd0;
         rdata_r <= 32'd0;
         rd_ok_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (launch) begin
            cnt     <= 8'd0;
            we_r    <= MemWrite_i;
            addr_r  <= ALU_i;
            wdata_r <= rt_i;
            rd_ok_r <= 1'b0;
         end else if (state == REQ && !mem_ack_i) begin
            cnt <= cnt + 8'd1;
         end
         if (ack_hit && !we_r) begin
            rdata_r <= mem_rdata_i;
            rd_ok_r <= 1'b1;
         end
         if (timed_out || misaligned)
            err_r <= 1'b1;
      end
   end

   assign mem_we_o    = we_r;
   assign mem_addr_o  = addr_r;
   assign mem_wdata_o = wdata_r;
   assign rdata_o     = rdata_r;
   assign err_o       = err_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (TIMEOUT=4): loads, stores, timeout, misalignment,
// back-to-back accesses and reset in the middle of a request.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        MemRead_i = 1'b0;
   logic        MemWrite_i = 1'b0;
   logic [31:0] ALU_i = 32'd0;
   logic [31:0] rt_i = 32'd0;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_rdata_i = 32'd0;
   logic        stall_o;
   logic [31:0] rdata_o;
   logic        rdata_valid_o;
   logic        err_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
      .ALU_i(ALU_i), .rt_i(rt_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .rdata_o(rdata_o),
      .rdata_valid_o(rdata_valid_o), .err_o(err_o)
   );

   task automatic test_reset;
      repeat (2) @(posedge clk);
      @(negedge clk);
      MemRead_i = 1'b1; ALU_i = 32'h40; #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", stall_o); end
      @(negedge clk); #1;
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", mem_req_o); end
      checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", mem_we_o); end
      checks++; if (mem_addr_o !== 32'd0) begin errors++; $display("FAIL rst_addr got=%h exp=0", mem_addr_o); end
      checks++; if (mem_wdata_o !== 32'd0) begin errors++; $display("FAIL rst_wdata got=%h exp=0", mem_wdata_o); end
      checks++; if (rdata_o !== 32'd0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", rdata_o); end
      checks++; if (rdata_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%b exp=0", rdata_valid_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err_o); end
      MemRead_i = 1'b0; ALU_i = 32'd0; rst = 1'b1;
   endtask

   task automatic test_load;
      int stall_cnt;
      @(negedge clk);
      MemRead_i = 1'b1; ALU_i = 32'h100; mem_rdata_i = 32'hDEADBEEF; #1;
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL load_stall_idle got=%b exp=1", stall_o); end
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL load_req_idle got=%b exp=0", mem_req_o); end
      stall_cnt = 1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         mem_ack_i = (c == 3); #1;
         if (stall_o) stall_cnt++;
         checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL load_req_c%0d got=%b exp=1", c, mem_req_o); end
         checks++; if (mem_addr_o !== 32'h100) begin errors++; $display("FAIL load_addr_c%0d got=%h exp=100", c, mem_addr_o); end
         checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL load_we_c%0d got=%b exp=0", c, mem_we_o); end
      end
      @(negedge clk);
      mem_ack_i = 1'b0; MemRead_i = 1'b0; ALU_i = 32'd0; #1;
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL load_req_done got=%b exp=0", mem_req_o); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL load_stall_done got=%b exp=0", stall_o); end
      checks++; if (rdata_valid_o !== 1'b1) begin errors++; $display("FAIL load_rvalid got=%b exp=1", rdata_valid_o); end
      checks++; if (rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got=%h exp=deadbeef", rdata_o); end
      checks++; if (stall_cnt !== 4) begin errors++; $display("FAIL load_stall_cycles got=%0d exp=4", stall_cnt); end
      @(negedge clk); #1;
      checks++; if (rdata_valid_o !== 1'b0) begin errors++; $display("FAIL load_rvalid_after got=%b exp=0", rdata_valid_o); end
      checks++; if (rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata_hold got=%h exp=deadbeef", rdata_o); end
   endtask

   task automatic test_store;
      @(negedge clk);
      MemWrite_i = 1'b1; ALU_i = 32'h20; rt_i = 32'h12345678; mem_rdata_i = 32'h0F0F0F0F; #1;
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL store_stall_idle got=%b exp=1", stall_o); end
      @(negedge clk);
      mem_ack_i = 1'b1; #1;
      checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL store_req got=%b exp=1", mem_req_o); end
      checks++; if (mem_we_o !== 1'b1) begin errors++; $display("FAIL store_we got=%b exp=1", mem_we_o); end
      checks++; if (mem_wdata_o !== 32'h12345678) begin errors++; $display("FAIL store_wdata got=%h exp=12345678", mem_wdata_o); end
      checks++; if (mem_addr_o !== 32'h20) begin errors++; $display("FAIL store_addr got=%h exp=20", mem_addr_o); end
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL store_stall_req got=%b exp=1", stall_o); end
      @(negedge clk);
      mem_ack_i = 1'b0; MemWrite_i = 1'b0; ALU_i = 32'd0; rt_i = 32'd0; #1;
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL store_req_done got=%b exp=0", mem_req_o); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL store_stall_done got=%b exp=0", stall_o); end
      checks++; if (rdata_valid_o !== 1'b0) begin errors++; $display("FAIL store_rvalid got=%b exp=0", rdata_valid_o); end
      checks++; if (rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL store_rdata got=%h exp=deadbeef", rdata_o); end
   endtask

   task automatic test_ack_at_limit;
      @(negedge clk);
      MemRead_i = 1'b1; ALU_i = 32'h400; mem_rdata_i = 32'h0BADF00D;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         mem_ack_i = (c == 4); #1;
         checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL limit_req_c%0d got=%b exp=1", c, mem_req_o); end
      end
      @(negedge clk);
      mem_ack_i = 1'b0; MemRead_i = 1'b0; ALU_i = 32'd0; #1;
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL limit_req_done got=%b exp=0", mem_req_o); end
      checks++; if (rdata_valid_o !== 1'b1) begin errors++; $display("FAIL limit_rvalid got=%b exp=1", rdata_valid_o); end
      checks++; if (rdata_o !== 32'h0BADF00D) begin errors++; $display("FAIL limit_rdata got=%h exp=0badf00d", rdata_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL limit_err got=%b exp=0", err_o); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      MemRead_i = 1'b1; ALU_i = 32'h500; mem_rdata_i = 32'h11111111;
      @(negedge clk);
      mem_ack_i = 1'b1;
      @(negedge clk);
      mem_ack_i = 1'b0; ALU_i = 32'h504; mem_rdata_i = 32'h22222222; #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL b2b_stall_done got=%b exp=0", stall_o); end
      checks++; if (rdata_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_rvalid_a got=%b exp=1", rdata_valid_o); end
      checks++; if (rdata_o !== 32'h11111111) begin errors++; $display("FAIL b2b_rdata_a got=%h exp=11111111", rdata_o); end
      @(negedge clk); #1;
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL b2b_stall_idle got=%b exp=1", stall_o); end
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL b2b_req_idle got=%b exp=0", mem_req_o); end
      @(negedge clk);
      mem_ack_i = 1'b1; #1;
      checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL b2b_req_b got=%b exp=1", mem_req_o); end
      checks++; if (mem_addr_o !== 32'h504) begin errors++; $display("FAIL b2b_addr_b got=%h exp=504", mem_addr_o); end
      @(negedge clk);
      mem_ack_i = 1'b0; MemRead_i = 1'b0; ALU_i = 32'd0; #1;
      checks++; if (rdata_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_rvalid_b got=%b exp=1", rdata_valid_o); end
      checks++; if (rdata_o !== 32'h22222222) begin errors++; $display("FAIL b2b_rdata_b got=%h exp=22222222", rdata_o); end
   endtask

   task automatic test_misaligned;
      @(negedge clk);
      MemRead_i = 1'b1; ALU_i = 32'h102; #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL mis_stall got=%b exp=0", stall_o); end
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL mis_req got=%b exp=0", mem_req_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL mis_err_before got=%b exp=0", err_o); end
      @(negedge clk);
      MemRead_i = 1'b0; ALU_i = 32'd0; #1;
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL mis_err got=%b exp=1", err_o); end
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL mis_req_after got=%b exp=0", mem_req_o); end
   endtask

   task automatic test_timeout;
      int n;
      @(negedge clk);
      MemRead_i = 1'b1; ALU_i = 32'h200; mem_rdata_i = 32'h99999999;
      n = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         if (!mem_req_o) break;
         n++;
      end
      MemRead_i = 1'b0; ALU_i = 32'd0; #1;
      checks++; if (n !== 4) begin errors++; $display("FAIL to_req_cycles got=%0d exp=4", n); end
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", err_o); end
      checks++; if (rdata_valid_o !== 1'b0) begin errors++; $display("FAIL to_rvalid got=%b exp=0", rdata_valid_o); end
      checks++; if (rdata_o !== 32'h22222222) begin errors++; $display("FAIL to_rdata got=%h exp=22222222", rdata_o); end
      @(negedge clk);
      MemRead_i = 1'b1; ALU_i = 32'h600; mem_rdata_i = 32'hCAFEF00D; #1;
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL to_next_stall got=%b exp=1", stall_o); end
      @(negedge clk);
      mem_ack_i = 1'b1; #1;
      checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL to_next_req got=%b exp=1", mem_req_o); end
      @(negedge clk);
      mem_ack_i = 1'b0; MemRead_i = 1'b0; ALU_i = 32'd0; #1;
      checks++; if (rdata_valid_o !== 1'b1) begin errors++; $display("FAIL to_next_rvalid got=%b exp=1", rdata_valid_o); end
      checks++; if (rdata_o !== 32'hCAFEF00D) begin errors++; $display("FAIL to_next_rdata got=%h exp=cafef00d", rdata_o); end
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL to_err_sticky got=%b exp=1", err_o); end
   endtask

   task automatic test_reset_in_req;
      @(negedge clk);
      MemRead_i = 1'b1; ALU_i = 32'h300; mem_rdata_i = 32'h55AA55AA;
      @(negedge clk); #1;
      checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL rreq_req got=%b exp=1", mem_req_o); end
      @(negedge clk);
      rst = 1'b0; MemRead_i = 1'b0; ALU_i = 32'd0; #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rreq_stall got=%b exp=0", stall_o); end
      @(negedge clk);
      rst = 1'b1; mem_ack_i = 1'b1; #1;
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rreq_req_after got=%b exp=0", mem_req_o); end
      checks++; if (mem_addr_o !== 32'd0) begin errors++; $display("FAIL rreq_addr got=%h exp=0", mem_addr_o); end
      checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL rreq_we got=%b exp=0", mem_we_o); end
      checks++; if (rdata_o !== 32'd0) begin errors++; $display("FAIL rreq_rdata got=%h exp=0", rdata_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rreq_err got=%b exp=0", err_o); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rreq_stall_after got=%b exp=0", stall_o); end
      @(negedge clk);
      mem_ack_i = 1'b0; #1;
      checks++; if (rdata_o !== 32'd0) begin errors++; $display("FAIL rreq_late_ack_rdata got=%h exp=0", rdata_o); end
      checks++; if (rdata_valid_o !== 1'b0) begin errors++; $display("FAIL rreq_late_ack_rvalid got=%b exp=0", rdata_valid_o); end
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rreq_late_ack_req got=%b exp=0", mem_req_o); end
   endtask

   initial begin
      test_reset;
      test_load;
      test_store;
      test_ack_at_limit;
      test_back_to_back;
      test_misaligned;
      test_timeout;
      test_reset_in_req;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
